hex_scan_driver: RTL

HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

---
 rtl/hex_scan_driver.sv | 133 +++++++++++++
 1 files changed

// File: rtl/hex_scan_driver.sv
// Four-digit multiplexed hex display scanner with frame-synchronous data update.
// Latency: outputs registered; a new slot appears the cycle after its prescaler tick.
// Backpressure: none; load is a strobe, and the last load before a frame boundary wins.
//
// Ports:
//   clk, rst_n          - system clock, asynchronous active-low reset
//   load, data_in       - capture strobe and four hex digits (digit k = data_in[4k+3:4k])
//   blank_lz            - suppress leading zero digits 3..1
//   b0..b3              - nibble of the active digit (b0 = MSB)
//   an                  - active-low digit enables, an[k] selects digit k
//   frame               - one-cycle pulse when the scan returns to digit 0
module hex_scan_driver #(
    parameter int CLK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] data_in,
    input  logic        blank_lz,
    output logic        b0,
    output logic        b1,
    output logic        b2,
    output logic        b3,
    output logic [3:0]  an,
    output logic        frame
);
    localparam int            CW   = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          started;
    logic [1:0]    idx;
    logic [15:0]   pending;
    logic          pending_valid;
    logic [15:0]   display;
    logic [3:0]    nib;

    logic          tick;
    logic          boundary;
    logic [1:0]    idx_nxt;
    logic [15:0]   display_nxt;
    logic [3:0]    digit;
    logic          z3, z2, z1;
    logic          blank;
    logic [3:0]    an_nxt;
    logic [3:0]    nib_nxt;

    // Output values are computed from the post-edge index and display so that
    // the registered outputs line up with the slot that starts on this edge.
    always_comb begin
        tick        = (cnt == LAST);
        boundary    = tick && (idx == 2'd3);
        idx_nxt     = tick ? idx + 2'd1 : idx;

        display_nxt = display;
        if (boundary) begin
            if (load) begin
                display_nxt = data_in;
            end else if (pending_valid) begin
                display_nxt = pending;
            end
        end

        case (idx_nxt)
            2'd0:    digit = display_nxt[3:0];
            2'd1:    digit = display_nxt[7:4];
            2'd2:    digit = display_nxt[11:8];
            default: digit = display_nxt[15:12];
        endcase

        // A digit is a leading zero when it and every digit above it are zero.
        z3 = (display_nxt[15:12] == 4'h0);
        z2 = z3 && (display_nxt[11:8] == 4'h0);
        z1 = z2 && (display_nxt[7:4] == 4'h0);

        case (idx_nxt)
            2'd3:    blank = blank_lz && z3;
            2'd2:    blank = blank_lz && z2;
            2'd1:    blank = blank_lz && z1;
            default: blank = 1'b0;
        endcase

        an_nxt  = blank ? 4'b1111 : ~(4'b0001 << idx_nxt);
        nib_nxt = blank ? 4'h0 : digit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            started       <= 1'b0;
            idx           <= 2'd0;
            pending       <= 16'h0000;
            pending_valid <= 1'b0;
            display       <= 16'h0000;
            nib           <= 4'h0;
            an            <= 4'b1111;
            frame         <= 1'b0;
        end else begin
            // The first edge after reset only lights digit 0; counting starts
            // after it so that every slot, including the first, is CLK_DIV long.
            started <= 1'b1;
            if (!started || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            idx     <= idx_nxt;
            display <= display_nxt;

            // A load on the boundary goes straight to display, so pending is
            // left alone and the valid flag is cleared.
            if (boundary) begin
                pending_valid <= 1'b0;
            end else if (load) begin
                pending       <= data_in;
                pending_valid <= 1'b1;
            end

            if (!started || tick) begin
                an  <= an_nxt;
                nib <= nib_nxt;
            end
            frame <= boundary;
        end
    end

    assign b0 = nib[3];
    assign b1 = nib[2];
    assign b2 = nib[1];
    assign b3 = nib[0];

endmodule
